prescaled_counter: RTL
======================

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 62_500_000: clk cycles per count step, legal range >= 1.
REQ-002 The block SHALL have parameter WIDTH, default 4: count width in bits, legal range >= 1.
REQ-003 The block SHALL have parameter MODULO, default 16: number of count states, legal range 2..2^WIDTH.
REQ-004 The block SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: run enable for prescaler and counter.
REQ-007 The block SHALL have port dir, input, 1 bit: 1 = count up, 0 = count down.
REQ-008 The block SHALL have port sat, input, 1 bit: 1 = saturate at the limit, 0 = wrap around.
REQ-009 The block SHALL have port clr, input, 1 bit: synchronous clear of count and prescaler.
REQ-010 The block SHALL have port load, input, 1 bit: synchronous load of count from load_val.
REQ-011 The block SHALL have port load_val, input, WIDTH bits: value to load.
REQ-012 The block SHALL have port count, output, WIDTH bits: current count, registered.
REQ-013 The block SHALL have port tick, output, 1 bit: one-cycle pulse on each prescaler step, registered.
REQ-014 The block SHALL have port tc, output, 1 bit: one-cycle terminal-count pulse, registered.

Function
REQ-015 The prescaler SHALL count 0..PRESCALE-1 while en=1 and SHALL hold its value while en=0.
REQ-016 A step SHALL occur on the edge where en=1 and prescaler=PRESCALE-1; the prescaler then returns to 0, giving exactly one step per PRESCALE enabled cycles.
REQ-017 With PRESCALE=1, a step SHALL occur on every enabled cycle and the prescaler register SHALL be 1 bit constant 0.
REQ-018 An up step SHALL apply count+1; at MODULO-1 the count SHALL wrap to 0 (sat=0) or hold at MODULO-1 (sat=1).
REQ-019 A down step SHALL apply count-1; at 0 the count SHALL wrap to MODULO-1 (sat=0) or hold at 0 (sat=1).
REQ-020 tick SHALL be 1 in the cycle after each step edge, coincident with the updated count.
REQ-021 tc SHALL pulse for one cycle, coincident with the updated count, when a step wraps or when a step first reaches the limit in saturate mode.
REQ-022 tc SHALL NOT pulse on steps blocked at the saturation limit, even though tick still pulses.
REQ-023 Priority SHALL be clr > load > step, evaluated per edge.
REQ-024 clr=1 SHALL set count=0 and prescaler=0 and suppress tick and tc, regardless of en.
REQ-025 load=1 (with clr=0) SHALL set count=min(load_val, MODULO-1), regardless of en.
REQ-026 load SHALL leave the prescaler running per REQ-015 and suppress any step, tick and tc on that edge.
REQ-027 A change of dir or sat SHALL take effect on the next step; the count SHALL never leave 0..MODULO-1.
REQ-028 Prescaler width SHALL be max(1, $clog2(PRESCALE)), and arithmetic SHALL not overflow at PRESCALE=2^n.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force count=0, prescaler=0, tick=0 and tc=0.
REQ-030 Release of rst_n SHALL take effect on the following clk edge; the first step SHALL come PRESCALE enabled cycles later.

Structure
REQ-031 Package counter_pkg SHALL hold the shared defaults: PRESCALE_1HZ_125MHZ = 125_000_000, PRESCALE_2HZ_125MHZ = 62_500_000, and the DIR_UP/DIR_DOWN encodings.
REQ-032 The prescaler SHALL be a sub-module, tick_gen (parameter PRESCALE; ports clk, rst_n, en, clr, step), and prescaled_counter SHALL instantiate it once.

Verification
All scenarios use PRESCALE=4, WIDTH=4 and MODULO=10 unless stated.
REQ-033 Scenario 1: en=1, dir=1, sat=0 from reset -> count steps every 4 cycles 0..9 then back to 0; tick every 4th cycle; tc once, coincident with count=0 after 9.
REQ-034 Scenario 2: load_val=2, then dir=0, sat=1 -> count 2,1,0 then holds 0; tc once at the 1->0 step; tick continues every 4 cycles.
REQ-035 Scenario 3: load_val=12 -> count=9; then clr=1 and load=1 on the same edge -> count=0, no tick or tc.
REQ-036 Scenario 4: en dropped for 10 cycles at prescaler=2 -> count frozen and no tick; after en=1 the next step comes 2 cycles later.
REQ-037 Scenario 5: rst_n asserted between edges at count=7 -> count=0 and tick=tc=0 before the next edge; after release the first step comes 4 cycles later.
REQ-038 Scenario 6: instance with PRESCALE=1, MODULO=16, up, wrap -> count increments every cycle; tc on each 15->0; tick constantly 1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared defaults for the prescaled counter block.
// Rates assume a 125 MHz reference clock.
package counter_pkg;

  localparam int unsigned PRESCALE_1HZ_125MHZ = 125_000_000;
  localparam int unsigned PRESCALE_2HZ_125MHZ = 62_500_000;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic int unsigned presc_w(input int unsigned p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: asserts step on the last of every PRESCALE
// enabled cycles; holds while en is low.
module tick_gen
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_2HZ_125MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int unsigned   PW   = presc_w(PRESCALE);
  // PRESCALE-1 always fits in PW bits, even at 2^n
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic          w_last;

  assign w_last = (r_pre == LAST);
  assign step   = en & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (clr) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= w_last ? '0 : r_pre + PW'(1);
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Up/down modulo counter advanced by a prescaled step,
// with wrap/saturate, clear, load, tick and terminal count.
module prescaled_counter
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_2HZ_125MHZ,
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULO   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_tc;
  logic             w_step;
  logic [WIDTH-1:0] w_nxt;
  logic             w_tc;
  logic [WIDTH-1:0] w_ld;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .step  (w_step)
  );

  assign w_ld = (load_val > MAX) ? MAX : load_val;

  // tc marks a wrap, or the step that first lands on the limit
  always_comb begin
    w_nxt = r_count;
    w_tc  = 1'b0;
    if (dir_e'(dir) == DIR_UP) begin
      if (r_count == MAX) begin
        if (!sat) begin
          w_nxt = '0;
          w_tc  = 1'b1;
        end
      end else begin
        w_nxt = r_count + WIDTH'(1);
        w_tc  = sat && (r_count == MAX - WIDTH'(1));
      end
    end else begin
      if (r_count == '0) begin
        if (!sat) begin
          w_nxt = MAX;
          w_tc  = 1'b1;
        end
      end else begin
        w_nxt = r_count - WIDTH'(1);
        w_tc  = sat && (r_count == WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
      if (clr) begin
        r_count <= '0;
      end else if (load) begin
        r_count <= w_ld;
      end else if (w_step) begin
        r_count <= w_nxt;
        r_tick  <= 1'b1;
        r_tc    <= w_tc;
      end
    end
  end

  assign count = r_count;
  assign tick  = r_tick;
  assign tc    = r_tc;

endmodule
